// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_wr_arbiter. The slave modport is the arbiter.
// The master modport is the surrounding producers and FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic [CNT_W-1:0]              rej_cnt;

  modport master (
    output req_valid, req_data, fifo_full, fifo_wr_ack,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, rej_cnt
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_wr_ack,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, rej_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port: accept -> wr_en next cycle -> ack check; 3 cycles/word, fifo_full stalls accept and issue.
// FIFO_ARB_RETRY_EN: when defined, a rejected word is re-issued instead of dropped.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       grant_nxt;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       idx;
  logic                  found;
  logic                  accept;
  logic                  issue;
  logic [FIFO_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]      rej_q;
  logic                  busy_q;
  logic [NUM_REQ-1:0]    ready_d;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
    end
  end

  // Reset masks the combinational strobes so nothing leaks out mid-reset.
  assign accept    = (state_q == ST_IDLE)  && found && !bus.fifo_full && !rst;
  assign issue     = (state_q == ST_ISSUE) && !bus.fifo_full && !rst;
  assign grant_nxt = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    ready_d = '0;
    if (accept) ready_d[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (issue)  state_d = ST_ACK;
      ST_ACK: begin
`ifdef FIFO_ARB_RETRY_EN
        state_d = bus.fifo_wr_ack ? ST_IDLE : ST_ISSUE;
`else
        state_d = ST_IDLE;
`endif
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      rej_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if (accept) begin
        hold_q  <= bus.req_data[int'(winner)*FIFO_WIDTH +: FIFO_WIDTH];
        grant_q <= winner;
      end
      if (state_q == ST_ACK) begin
        if (bus.fifo_wr_ack) begin
          ptr_q <= grant_nxt;
        end else begin
          if (rej_q != '1) rej_q <= rej_q + CNT_W'(1);
`ifndef FIFO_ARB_RETRY_EN
          ptr_q <= grant_nxt;
`endif
        end
      end
    end
  end

  assign bus.req_ready    = ready_d;
  assign bus.fifo_wr_en   = issue;
  assign bus.fifo_data_in = hold_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = busy_q;
  assign bus.rej_cnt      = rej_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single producer, fairness, full stall, rejection and counter saturation.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16), .CNT_W(8)) bus();

  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_seen;
    int busy_seen;
    int exp_g;

    rst             = 1'b1;
    bus.req_valid   = 4'hF;
    bus.req_data    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.fifo_full   = 1'b0;
    bus.fifo_wr_ack = 1'b0;
    step();
    step();
    #1;
    chk("rst_ready",   bus.req_ready, 4'b0000);
    chk("rst_wr_en",   bus.fifo_wr_en, 1'b0);
    chk("rst_busy",    bus.busy, 1'b0);
    chk("rst_grant",   bus.grant_id, 2'd0);
    chk("rst_rej",     bus.rej_cnt, 8'd0);
    chk("rst_data_in", bus.fifo_data_in, 16'h0000);
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    step();

    // single producer 2
    bus.req_valid = 4'b0100;
    bus.req_data[47:32] = 16'hA5A5;
    #1;
    chk("single_ready_t", bus.req_ready, 4'b0100);
    chk("single_busy_t",  bus.busy, 1'b0);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_wr_en_t1", bus.fifo_wr_en, 1'b1);
    chk("single_data_t1",  bus.fifo_data_in, 16'hA5A5);
    chk("single_grant_t1", bus.grant_id, 2'd2);
    chk("single_busy_t1",  bus.busy, 1'b1);
    chk("single_ready_t1", bus.req_ready, 4'b0000);
    step();
    bus.fifo_wr_ack = 1'b1;
    #1;
    chk("single_wr_en_t2", bus.fifo_wr_en, 1'b0);
    chk("single_busy_t2",  bus.busy, 1'b1);
    step();
    bus.fifo_wr_ack = 1'b0;
    #1;
    chk("single_busy_t3", bus.busy, 1'b0);
    chk("single_hold_t3", bus.fifo_data_in, 16'hA5A5);

    // reset during ISSUE
    bus.req_valid = 4'b0010;
    bus.req_data[31:16] = 16'h1234;
    #1;
    chk("rstmid_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("rstmid_issue_wr_en", bus.fifo_wr_en, 1'b1);
    chk("rstmid_issue_grant", bus.grant_id, 2'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_override", bus.fifo_wr_en, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid_wr_en", bus.fifo_wr_en, 1'b0);
    chk("rstmid_busy",  bus.busy, 1'b0);
    chk("rstmid_rej",   bus.rej_cnt, 8'd0);
    chk("rstmid_grant", bus.grant_id, 2'd0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.fifo_wr_en === 1'b1) wr_seen++;
    end
    chk("rstmid_no_write", wr_seen, 0);

    // fairness, all producers valid, FIFO always acks
    bus.req_valid = 4'hF;
    bus.req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    for (int g = 0; g < 12; g++) begin
      exp_g = g % 4;
      #1;
      chk("fair_ready", bus.req_ready, 32'(1 << exp_g));
      step();
      chk("fair_grant", bus.grant_id, exp_g);
      chk("fair_data",  bus.fifo_data_in, 32'h1000 + exp_g);
      chk("fair_wr_en", bus.fifo_wr_en, 1'b1);
      step();
      bus.fifo_wr_ack = 1'b1;
      step();
      bus.fifo_wr_ack = 1'b0;
    end
    bus.req_valid = 4'b0000;

    // full blocks acceptance in IDLE, then holds the word in ISSUE
    bus.req_data[31:16] = 16'hBEEF;
    bus.req_valid = 4'b0010;
    bus.fifo_full = 1'b1;
    #1;
    chk("full_idle_ready", bus.req_ready, 4'b0000);
    step();
    chk("full_idle_busy", bus.busy, 1'b0);
    bus.fifo_full = 1'b0;
    #1;
    chk("full_accept_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b0000;
    bus.fifo_full = 1'b1;
    wr_seen   = 0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.fifo_wr_en !== 1'b0) wr_seen++;
      if (bus.busy === 1'b1) busy_seen++;
      step();
    end
    chk("full_no_wr_en", wr_seen, 0);
    chk("full_busy",     busy_seen, 5);
    bus.fifo_full = 1'b0;
    #1;
    chk("full_release_wr_en", bus.fifo_wr_en, 1'b1);
    chk("full_release_data",  bus.fifo_data_in, 16'hBEEF);
    chk("full_release_grant", bus.grant_id, 2'd1);
    step();
    bus.fifo_wr_ack = 1'b1;
    #1;
    chk("full_ack_wr_en", bus.fifo_wr_en, 1'b0);
    step();
    bus.fifo_wr_ack = 1'b0;
    #1;
    chk("full_done_busy", bus.busy, 1'b0);

    // one rejection; pointer is now 2
    bus.req_data[47:32] = 16'hC0DE;
    bus.req_valid = 4'b0100;
    #1;
    chk("rej_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("rej_issue_data", bus.fifo_data_in, 16'hC0DE);
    step();
    bus.fifo_wr_ack = 1'b0;
    #1;
    chk("rej_cnt_before", bus.rej_cnt, 8'd0);
    step();
`ifdef FIFO_ARB_RETRY_EN
    #1;
    chk("retry_busy",  bus.busy, 1'b1);
    chk("retry_wr_en", bus.fifo_wr_en, 1'b1);
    chk("retry_data",  bus.fifo_data_in, 16'hC0DE);
    chk("retry_grant", bus.grant_id, 2'd2);
    chk("retry_rej",   bus.rej_cnt, 8'd1);
    step();
    bus.fifo_wr_ack = 1'b1;
    step();
    bus.fifo_wr_ack = 1'b0;
`else
    #1;
    chk("drop_busy",  bus.busy, 1'b0);
    chk("drop_wr_en", bus.fifo_wr_en, 1'b0);
    chk("drop_rej",   bus.rej_cnt, 8'd1);
`endif
    // pointer is 3 either way, so producer 0 beats producer 2
    bus.req_data[15:0] = 16'h0A0A;
    bus.req_valid = 4'b0101;
    #1;
    chk("ptr_adv_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("ptr_adv_grant", bus.grant_id, 2'd0);
    step();
    bus.fifo_wr_ack = 1'b1;
    step();
    bus.fifo_wr_ack = 1'b0;

`ifndef FIFO_ARB_RETRY_EN
    // 300 rejected writes: grants keep rotating, counter saturates
    bus.req_valid = 4'hF;
    for (int k = 0; k < 300; k++) begin
      exp_g = (1 + k) % 4;
      #1;
      step();
      chk("sat_grant", bus.grant_id, exp_g);
      step();
      step();
      if (k == 252) chk("sat_rej_254", bus.rej_cnt, 8'd254);
      if (k == 253) chk("sat_rej_255", bus.rej_cnt, 8'd255);
    end
    bus.req_valid = 4'b0000;
    #1;
    chk("sat_rej_final", bus.rej_cnt, 8'd255);
    step();
    chk("sat_idle_busy", bus.busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port between `NUM_REQ` producers. Each producer offers a word with a valid/ready handshake; the arbiter accepts one word at a time, issues it to the FIFO as a single-cycle `wr_en` pulse, and checks the FIFO's registered `wr_ack`. It sits directly in front of the FIFO write side. The FIFO's `full` and `wr_ack` outputs connect straight to this block.

## Interface
- `NUM_REQ`, default 4: number of producers, ≥2.
- `FIFO_WIDTH`, default 16: data word width; must match the FIFO.
- `CNT_W`, default 8: width of the rejection counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  producer i offers a word.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  producer i word in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot, single-cycle accept pulse to the winner.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_ack`  in  1  FIFO registered write acknowledge.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_data_in`  out  FIFO_WIDTH  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last winner.
- `busy`  out  1  high whenever the state is not IDLE.
- `rej_cnt`  out  CNT_W  saturating count of rejected writes.

## Operation
- **States:** IDLE, ISSUE, ACK.
- **Round-robin pointer `p`:** reset value 0.
  - The winner is the first i with `req_valid[i]`=1, searching p, p+1, … modulo NUM_REQ.
- **IDLE:**
  - If any `req_valid` is high and `fifo_full`=0, the following happen in the same cycle:
    - `req_ready[winner]`=1, combinational.
    - The winner's word is registered into a hold register.
    - `grant_id`←winner.
    - The state moves to ISSUE.
  - Otherwise the block stays in IDLE with `req_ready`=0.
- **ISSUE:**
  - If `fifo_full`=0: `fifo_wr_en`=1 and `fifo_data_in`=hold for exactly this cycle, then move to ACK.
  - If `fifo_full`=1: `fifo_wr_en`=0 and the block stays in ISSUE. The word is held indefinitely.
- **ACK:** `fifo_wr_en`=0.
  - If `fifo_wr_ack`=1: write complete. p←(grant_id+1) mod NUM_REQ, then go to IDLE.
  - If `fifo_wr_ack`=0: rejected. `rej_cnt` increments and saturates at all-ones. The next action depends on the configuration (see Configuration).
- **Producer rule:** a producer holds `req_valid` and its data stable until it sees its `req_ready` pulse. Deasserting `req_valid` before acceptance is legal; that producer is simply skipped.
- **Output values:**
  - `fifo_data_in` holds its last value outside ISSUE.
  - `req_ready` is never high outside IDLE.
- **Reset:**
  - The held word is discarded; no write follows.
  - State←IDLE, p←0.
  - All outputs←0: `req_ready`, `fifo_wr_en`, `fifo_data_in`, `grant_id`, `busy`, `rej_cnt`.
  - Reset overrides every state, including the cycle in which `fifo_wr_en` would be asserted.

## Timing
- **Accept to write:** acceptance in cycle t gives `fifo_wr_en` in t+1 at the earliest. `wr_ack` is sampled in t+2. The next acceptance is possible in t+3.
- **Throughput:** one word per 3 cycles when the FIFO is not full.
- **Full in ISSUE:** each cycle spent in ISSUE with `fifo_full`=1 adds one cycle.
- **Fairness:** with all producers permanently valid, grants rotate 0,1,…,NUM_REQ-1,0.
  - No producer waits more than NUM_REQ-1 grants.
- **`busy`:** a registered state decode, high in ISSUE and ACK.
- **`grant_id` update:** updates in the same clock edge that leaves IDLE.

## Configuration
- **Macro `FIFO_ARB_RETRY_EN`:**
  - **Defined:** after a rejection in ACK, the state returns to ISSUE with the same held word and the same `grant_id`. p is unchanged. The word is re-issued when `fifo_full`=0, so no data is lost.
  - **Undefined:** after a rejection, the word is dropped. p←(grant_id+1) mod NUM_REQ and the state goes to IDLE.
- In both modes `rej_cnt` counts every rejection.

## Test plan
- **Reset mid-write:**
  - Stimulus: assert `rst` during ISSUE with `fifo_full`=0.
  - Required: next cycle `fifo_wr_en`=0, `busy`=0, `rej_cnt`=0, `grant_id`=0. No write of the held word ever appears.
- **Single producer:**
  - Stimulus: `req_valid`=4'b0100, data 16'hA5A5, FIFO acks.
  - Required: `req_ready`=4'b0100 in t; `fifo_wr_en`=1 with 16'hA5A5 in t+1; `busy` low in t+3.
- **Fairness:**
  - Stimulus: `req_valid`=4'b1111 held for 12 grants, FIFO always acks.
  - Required: `grant_id` sequence 0,1,2,3,0,1,2,3,0,1,2,3.
- **Full hold:**
  - Stimulus: `fifo_full`=1 for 5 cycles while in ISSUE.
  - Required: `fifo_wr_en` stays 0 for those 5 cycles and pulses once after `fifo_full` falls, with unchanged data.
- **Rejection with `FIFO_ARB_RETRY_EN` defined:**
  - Stimulus: force `fifo_wr_ack`=0 once.
  - Required: the same word is re-issued on the next `wr_en`; `rej_cnt`=1; `grant_id` unchanged.
- **Rejection without the macro, plus saturation:**
  - Stimulus: force `fifo_wr_ack`=0 on 300 writes.
  - Required: each word is dropped and p advances; `rej_cnt` saturates at 255.
